// File: rtl/aes_pkg.sv
// Shared AES definitions: byte type, SubBytes FSM states and S-box tables.
package aes_pkg;

    typedef logic [7:0] aes_byte_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sbe_state_e;

    localparam aes_byte_t FWD_SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam aes_byte_t INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/sbox_lane.sv
// Single combinational S-box lane.
// AES_SBOX_FWD_EN: adds the forward table and honours inv; otherwise inverse only.
module sbox_lane
    import aes_pkg::*;
(
    input  logic      inv,
    input  aes_byte_t data_in,
    output aes_byte_t data_out
);

`ifdef AES_SBOX_FWD_EN
    // Mode-selected table lookup
    always_comb begin
        data_out = inv ? INV_SBOX[data_in] : FWD_SBOX[data_in];
    end
`else
    // Decrypt-only lane: mode input has no effect
    logic unused_inv;
    assign unused_inv = inv;

    always_comb begin
        data_out = INV_SBOX[data_in];
    end
`endif

endmodule

// File: rtl/sub_bytes_engine.sv
// Iterative SubBytes/InvSubBytes engine: LANES bytes per cycle over an NBYTES state.
// AES_SBOX_FWD_EN: enables forward substitution; otherwise in_inv is treated as 1.
module sub_bytes_engine
    import aes_pkg::*;
#(
    parameter int unsigned NBYTES = 16,
    parameter int unsigned LANES  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*NBYTES-1:0] in_data,
    input  logic                in_inv,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] out_data,
    output logic                busy
);

    localparam int unsigned NGROUPS = NBYTES / LANES;
    localparam int unsigned CW      = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
    localparam logic [CW-1:0] LAST_GROUP = CW'(NGROUPS - 1);

    // Reject lane counts the lane mux cannot tile
    if (!((LANES == 1) || (LANES == 2) || (LANES == 4) || (LANES == 8) || (LANES == 16))
        || ((NBYTES % LANES) != 0)) begin : g_bad_cfg
        $error("sub_bytes_engine: LANES must be 1,2,4,8 or 16 and divide NBYTES");
    end

    sbe_state_e                  state_q;
    sbe_state_e                  state_nxt;
    aes_byte_t [NBYTES-1:0]      work_q;
    aes_byte_t [NBYTES-1:0]      work_nxt;
    aes_byte_t [LANES-1:0]       lane_in;
    aes_byte_t [LANES-1:0]       lane_out;
    logic [CW-1:0]               cnt_q;
    logic                        inv_q;
    logic                        mode_in;
    logic                        accept;
    logic                        last_group;
    logic                        in_ready_nxt;
    logic                        out_valid_nxt;
    logic                        busy_nxt;

`ifdef AES_SBOX_FWD_EN
    assign mode_in = in_inv;
`else
    logic unused_in_inv;
    assign unused_in_inv = in_inv;
    assign mode_in       = 1'b1;
`endif

    assign accept     = in_valid & in_ready;
    assign last_group = (state_q == RUN) && (cnt_q == LAST_GROUP);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            IDLE:    if (accept)                 state_nxt = RUN;
            RUN:     if (last_group)             state_nxt = DONE;
            DONE:    if (out_valid && out_ready) state_nxt = IDLE;
            default:                             state_nxt = IDLE;
        endcase
    end

    // Handshake/status outputs decoded from the upcoming state
    always_comb begin
        in_ready_nxt  = 1'b0;
        out_valid_nxt = 1'b0;
        busy_nxt      = 1'b0;
        unique case (state_nxt)
            IDLE:    in_ready_nxt  = 1'b1;
            RUN:     busy_nxt      = 1'b1;
            DONE: begin
                out_valid_nxt = 1'b1;
                busy_nxt      = 1'b1;
            end
            default: in_ready_nxt  = 1'b1;
        endcase
    end

    // Registered handshake/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            busy      <= busy_nxt;
        end
    end

    // Select the current byte group from the work register
    always_comb begin
        lane_in = '0;
        for (int unsigned g = 0; g < NGROUPS; g++) begin
            if (cnt_q == CW'(g)) begin
                for (int unsigned l = 0; l < LANES; l++) begin
                    lane_in[l] = work_q[g*LANES + l];
                end
            end
        end
    end

    // Parallel S-box lanes
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        sbox_lane u_sbox_lane (
            .inv      (inv_q),
            .data_in  (lane_in[l]),
            .data_out (lane_out[l])
        );
    end

    // Write substituted group back in place
    always_comb begin
        work_nxt = work_q;
        for (int unsigned g = 0; g < NGROUPS; g++) begin
            if (cnt_q == CW'(g)) begin
                for (int unsigned l = 0; l < LANES; l++) begin
                    work_nxt[g*LANES + l] = lane_out[l];
                end
            end
        end
    end

    // Work register, step counter, latched mode and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q   <= '0;
            cnt_q    <= '0;
            inv_q    <= 1'b0;
            out_data <= '0;
        end else begin
            if ((state_q == IDLE) && accept) begin
                work_q <= in_data;
                cnt_q  <= '0;
                inv_q  <= mode_in;
            end else if (state_q == RUN) begin
                work_q <= work_nxt;
                cnt_q  <= last_group ? '0 : cnt_q + CW'(1);
                if (last_group) begin
                    out_data <= work_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Self-checking bench for sub_bytes_engine: LANES=4, 1 and 16 instances.
// Expected values come from an algebraic GF(2^8) S-box model and a scoreboard queue.
// Build with +define+AES_SBOX_FWD_EN to exercise the forward/round-trip tests.
module tb_sub_bytes_engine;

    logic         clk;
    logic         rst_n;
    logic [2:0]   in_valid;
    logic [2:0]   in_ready;
    logic [2:0]   in_inv;
    logic [2:0]   out_valid;
    logic [2:0]   out_ready;
    logic [2:0]   busy;
    logic [127:0] in_data  [3];
    logic [127:0] out_data [3];

    logic [127:0] exp_q [$];
    logic [7:0]   inv_tab [256];
    int           n_tests;
    int           n_fail;

    sub_bytes_engine #(.NBYTES(16), .LANES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_inv(in_inv[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0])
    );

    sub_bytes_engine #(.NBYTES(16), .LANES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_inv(in_inv[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1])
    );

    sub_bytes_engine #(.NBYTES(16), .LANES(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .in_inv(in_inv[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_data(out_data[2]), .busy(busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic       hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    // Forward S-box: multiplicative inverse (x^254) followed by the affine map
    function automatic logic [7:0] fwd_model(input logic [7:0] x);
        logic [7:0] r, base, s;
        int         e;
        r = 8'h01; base = x; e = 254;
        while (e != 0) begin
            if (e % 2 == 1) r = gf_mul(r, base);
            base = gf_mul(base, base);
            e = e / 2;
        end
        s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] din, input logic inv);
        logic [127:0] r;
        logic [7:0]   b;
        logic         eff;
`ifdef AES_SBOX_FWD_EN
        eff = inv;
`else
        eff = inv | 1'b1;
`endif
        for (int i = 0; i < 16; i++) begin
            b = din[8*i +: 8];
            r[8*i +: 8] = eff ? inv_tab[b] : fwd_model(b);
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Push one state through DUT d; checks handshake, latency, hold behaviour and data
    task automatic run_state(input int d, input logic [127:0] din, input logic inv,
                             input int exp_lat, input bit toggle, input int hold,
                             output logic [127:0] res);
        int           lat;
        logic [127:0] snap;
        logic [127:0] exp;
        check("ready_idle", 128'(in_ready[d]), 128'd1);
        in_data[d]   = din;
        in_inv[d]    = inv;
        in_valid[d]  = 1'b1;
        out_ready[d] = 1'b0;
        exp_q.push_back(model(din, inv));
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        in_data[d]  = rand128();
        check("ready_run", 128'(in_ready[d]), 128'd0);
        check("busy_run", 128'(busy[d]), 128'd1);
        lat = 0;
        while (!out_valid[d] && lat < 64) begin
            if (toggle) in_inv[d] = ~in_inv[d];
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 128'(lat), 128'(exp_lat));
        snap = out_data[d];
        for (int c = 0; c < hold; c++) begin
            in_valid[d] = 1'b1;
            in_data[d]  = rand128();
            in_inv[d]   = ~in_inv[d];
            @(posedge clk); #1;
            check("hold_valid", 128'(out_valid[d]), 128'd1);
            check("hold_data", out_data[d], snap);
            check("hold_ready", 128'(in_ready[d]), 128'd0);
        end
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b1;
        res = out_data[d];
        exp = exp_q.pop_front();
        check("data", res, exp);
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
        check("valid_drop", 128'(out_valid[d]), 128'd0);
        check("ready_back", 128'(in_ready[d]), 128'd1);
        check("data_kept", out_data[d], res);
    endtask

    initial begin
        logic [127:0] r1, r2, x;
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 256; i++) inv_tab[fwd_model(8'(i))] = 8'(i);

        rst_n     = 1'b0;
        in_valid  = '0;
        in_inv    = '0;
        out_ready = '0;
        for (int d = 0; d < 3; d++) in_data[d] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state
        check("rst_in_ready", 128'(in_ready), 128'(3'b111));
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_out_data", out_data[0], 128'd0);

        // All-zero state, inverse
        run_state(0, 128'd0, 1'b1, 4, 1'b0, 0, r1);
        check("zero_inv_const", r1, {16{8'h52}});

        // Incrementing bytes, inverse
        x = 128'h0f0e0d0c0b0a09080706050403020100;
        run_state(0, x, 1'b1, 4, 1'b0, 0, r1);
        check("inc_b0", 128'(r1[7:0]), 128'h52);
        check("inc_b1", 128'(r1[15:8]), 128'h09);
        check("inc_b2", 128'(r1[23:16]), 128'h6a);
        check("inc_b3", 128'(r1[31:24]), 128'hd5);
        check("inc_b15", 128'(r1[127:120]), 128'hfb);

`ifdef AES_SBOX_FWD_EN
        // Forward then inverse round trip
        run_state(0, {16{8'h63}}, 1'b0, 4, 1'b0, 0, r1);
        check("fwd_63", r1, {16{8'hfb}});
        run_state(0, r1, 1'b1, 4, 1'b0, 0, r2);
        check("rt_63", r2, {16{8'h63}});
        for (int n = 0; n < 200; n++) begin
            x = rand128();
            run_state(0, x, 1'b0, 4, 1'b0, 0, r1);
            run_state(0, r1, 1'b1, 4, 1'b0, 0, r2);
            check("rt_rand", r2, x);
        end
`else
        // Decrypt-only build: random states with mode input ignored
        for (int n = 0; n < 100; n++) begin
            run_state(0, rand128(), 1'($urandom_range(0, 1)), 4, 1'b0, 0, r1);
        end
`endif

        // Backpressure: out_ready low for 10 cycles in DONE
        run_state(0, rand128(), 1'b1, 4, 1'b0, 10, r1);

        // Reset after two RUN steps discards the partial state
        in_data[0]  = rand128();
        in_inv[0]   = 1'b1;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_busy", 128'(busy[0]), 128'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 128'(in_ready[0]), 128'd1);
        check("mid_rst_out_valid", 128'(out_valid[0]), 128'd0);
        check("mid_rst_out_data", out_data[0], 128'd0);
        check("mid_rst_busy", 128'(busy[0]), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_out_valid", 128'(out_valid[0]), 128'd0);
        run_state(0, rand128(), 1'b1, 4, 1'b0, 0, r1);

        // LANES=1 and LANES=16 builds, mode toggled during RUN
        x = rand128();
        x[127:120] = 8'hff;
        run_state(1, x, 1'b1, 16, 1'b1, 0, r1);
        check("l1_b15", 128'(r1[127:120]), 128'h7d);
        run_state(1, rand128(), 1'b1, 16, 1'b1, 2, r1);
        x = rand128();
        x[127:120] = 8'hff;
        run_state(2, x, 1'b1, 1, 1'b1, 0, r1);
        check("l16_b15", 128'(r1[127:120]), 128'h7d);
        run_state(2, rand128(), 1'b1, 1, 1'b1, 2, r1);

        check("sb_empty", 128'(exp_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
